// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin arbiter that time-shares a single unsigned
// comparator between NREQ requesters. One transaction takes three cycles:
// IDLE (grant + operand capture), CMP (flags captured, done raised) and
// RESP (grant/done dropped, pointer advanced).

// Unsigned comparator; gt/lt are expressed as "b relative to a".
module COMP #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq
);

  assign gt = (b > a);
  assign lt = (b < a);
  assign eq = (b == a);

endmodule

module comp_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_bus,
  input  logic [NREQ*DATAWIDTH-1:0] b_bus,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      gt,
  output logic                      lt,
  output logic                      eq,
  output logic                      busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         ptr_reg, ptr_next;
  logic [PW-1:0]         sel_reg, sel_next;
  logic [DATAWIDTH-1:0]  a_r, a_next;
  logic [DATAWIDTH-1:0]  b_r, b_next;
  logic [NREQ-1:0]       gnt_reg, gnt_next;
  logic [NREQ-1:0]       done_reg, done_next;
  logic                  gt_reg, gt_next;
  logic                  lt_reg, lt_next;
  logic                  eq_reg, eq_next;

  logic                  comp_gt, comp_lt, comp_eq;
  logic [DATAWIDTH-1:0]  a_slice [NREQ];
  logic [DATAWIDTH-1:0]  b_slice [NREQ];
  logic [PW-1:0]         pick;
  logic                  found;
  int                    j;

  // Split the flat operand buses into per-requester slices.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_slice[gi] = a_bus[gi*DATAWIDTH +: DATAWIDTH];
      assign b_slice[gi] = b_bus[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  // The shared comparator only ever sees the captured operands, so bus
  // changes after the grant edge cannot disturb the result.
  COMP #(
    .DATAWIDTH(DATAWIDTH)
  ) u_comp (
    .a (a_r),
    .b (b_r),
    .gt(comp_gt),
    .lt(comp_lt),
    .eq(comp_eq)
  );

  // Round-robin pick: first set request at or above ptr, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_reg) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (!found && req[PW'(j)]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  // Next-state and next-output logic for the three-phase sequence.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    a_next     = a_r;
    b_next     = b_r;
    gnt_next   = gnt_reg;
    done_next  = done_reg;
    gt_next    = gt_reg;
    lt_next    = lt_reg;
    eq_next    = eq_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          sel_next   = pick;
          a_next     = a_slice[pick];
          b_next     = b_slice[pick];
          gnt_next   = NREQ'(1) << pick;
          state_next = CMP;
        end
      end
      CMP: begin
        gt_next    = comp_gt;
        lt_next    = comp_lt;
        eq_next    = comp_eq;
        done_next  = gnt_reg;
        state_next = RESP;
      end
      RESP: begin
        gnt_next  = '0;
        done_next = '0;
        if (sel_reg == PW'(NREQ - 1)) begin
          ptr_next = '0;
        end else begin
          ptr_next = sel_reg + PW'(1);
        end
        state_next = IDLE;
      end
      default: begin
        gnt_next   = '0;
        done_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State register plus arbitration bookkeeping; reset aborts any transaction.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
    end
  end

  // Operand capture, grant/done strobes and result flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_r      <= '0;
      b_r      <= '0;
      gnt_reg  <= '0;
      done_reg <= '0;
      gt_reg   <= 1'b0;
      lt_reg   <= 1'b0;
      eq_reg   <= 1'b0;
    end else begin
      a_r      <= a_next;
      b_r      <= b_next;
      gnt_reg  <= gnt_next;
      done_reg <= done_next;
      gt_reg   <= gt_next;
      lt_reg   <= lt_next;
      eq_reg   <= eq_next;
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign gt   = gt_reg;
  assign lt   = lt_reg;
  assign eq   = eq_reg;
  assign busy = (state_reg != IDLE);

endmodule
